// File: rtl/axi4_master_bridge.sv
// Single-outstanding AXI4 initiator: turns a core request/response port into
// single-beat AXI4 reads and writes. All bus-facing outputs come from registers.
module axi4_master_bridge #(
  parameter logic [3:0] ID = 4'h0
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [63:0] io_master_wdata,
  output logic [7:0]  io_master_wstrb,
  output logic        io_master_wlast,
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [63:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic [2:0]  dbg_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both high; a raised valid holds with a stable
  // payload until that edge, and ready may be raised independently of valid.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_hs, w_hs;
  logic        unused_resp_lsb;

  assign aw_hs = awvalid_q & io_master_awready;
  assign w_hs  = wvalid_q & io_master_wready;
  assign unused_resp_lsb = ^{io_master_rresp[0], io_master_bresp[0]};

  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    rdata_d      = rdata_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AR: begin
        if (io_master_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (io_master_rvalid) begin
          rready_d     = 1'b0;
          rdata_d      = io_master_rdata;
          resp_valid_d = 1'b1;
          resp_err_d   = io_master_rresp[1] | ~io_master_rlast | (io_master_rid != ID);
          state_d      = S_IDLE;
        end
      end
      S_WR: begin
        // AW and W complete independently; B waits for both.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = S_B;
        end
      end
      S_B: begin
        if (io_master_bvalid) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = io_master_bresp[1] | (io_master_bid != ID);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  assign req_ready         = (state_q == S_IDLE);
  assign dbg_state         = state_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = rdata_q;
  assign resp_err          = resp_err_q;

  assign io_master_awvalid = awvalid_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = ID;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid  = wvalid_q;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = bready_q;
  assign io_master_arvalid = arvalid_q;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = ID;
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = 2'b01;
  assign io_master_rready  = rready_q;

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Bench for axi4_master_bridge: directed slave behaviour per scenario with an
// expected-response queue checked whenever resp_valid pulses.
module tb_axi4_master_bridge;

  localparam int W = 65;  // {err, rdata}

  logic        clock;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        io_master_awready;
  logic        io_master_awvalid;
  logic [31:0] io_master_awaddr;
  logic [3:0]  io_master_awid;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;
  logic        io_master_wready;
  logic        io_master_wvalid;
  logic [63:0] io_master_wdata;
  logic [7:0]  io_master_wstrb;
  logic        io_master_wlast;
  logic        io_master_bready;
  logic        io_master_bvalid;
  logic [1:0]  io_master_bresp;
  logic [3:0]  io_master_bid;
  logic        io_master_arready;
  logic        io_master_arvalid;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rready;
  logic        io_master_rvalid;
  logic [1:0]  io_master_rresp;
  logic [63:0] io_master_rdata;
  logic        io_master_rlast;
  logic [3:0]  io_master_rid;
  logic [2:0]  dbg_state;

  axi4_master_bridge #(.ID(4'h0)) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wready(io_master_wready), .io_master_wvalid(io_master_wvalid),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rready(io_master_rready), .io_master_rvalid(io_master_rvalid),
    .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  int           resp_cyc_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           resp_cnt = 0;
  int           overlap_cnt = 0;
  logic [63:0]  model_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      if ((io_master_arvalid | io_master_rready) &
          (io_master_awvalid | io_master_wvalid | io_master_bready))
        overlap_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        resp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, exp_e[63:0]);
          check("resp_err", 64'(resp_err), 64'(exp_e[64]));
        end
      end
    end
  end

  // driver tasks
  task automatic slave_idle();
    io_master_awready = 1'b0; io_master_wready = 1'b0;
    io_master_bvalid = 1'b0; io_master_bresp = 2'b00; io_master_bid = 4'h0;
    io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rresp = 2'b00;
    io_master_rdata = '0; io_master_rlast = 1'b1; io_master_rid = 4'h0;
  endtask

  task automatic slave_ready(input logic [63:0] rd);
    io_master_awready = 1'b1; io_master_wready = 1'b1;
    io_master_bvalid = 1'b1; io_master_bresp = 2'b00; io_master_bid = 4'h0;
    io_master_arready = 1'b1; io_master_rvalid = 1'b1; io_master_rresp = 2'b00;
    io_master_rdata = rd; io_master_rlast = 1'b1; io_master_rid = 4'h0;
  endtask

  task automatic push_read(input logic err, input logic [63:0] rd);
    model_rdata = rd;
    exp_q.push_back({err, rd});
  endtask

  task automatic push_write(input logic err);
    exp_q.push_back({err, model_rdata});
  endtask

  // Presents one request starting #1 after a posedge; returns its accept cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [63:0] wd, input logic [7:0] ws, output int acc);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_wdata = wd; req_wstrb = ws;
    acc = cyc;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 50) begin
      @(posedge clock); #1; n++;
    end
    check("resp_timeout", 64'(resp_cnt >= target), 64'd1);
  endtask

  int acc;
  int start;
  int acc_q[4];

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0;
    slave_idle();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_arvalid", 64'(io_master_arvalid), 64'd0);
    check("rst_awvalid", 64'(io_master_awvalid), 64'd0);
    check("rst_wvalid", 64'(io_master_wvalid), 64'd0);
    check("rst_rready", 64'(io_master_rready), 64'd0);
    check("rst_bready", 64'(io_master_bready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_araddr", 64'(io_master_araddr), 64'd0);
    check("rst_wdata", io_master_wdata, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(posedge clock); #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // read against an always-ready slave
    slave_ready(64'h0000_0000_0000_0413);
    push_read(1'b0, 64'h0000_0000_0000_0413);
    start = resp_cnt;
    issue(1'b0, 32'h8000_0000, 3'd3, 64'd0, 8'd0, acc);
    check("rd_arvalid", 64'(io_master_arvalid), 64'd1);
    check("rd_araddr", 64'(io_master_araddr), 64'h8000_0000);
    check("rd_arsize", 64'(io_master_arsize), 64'd3);
    check("rd_arlen", 64'(io_master_arlen), 64'd0);
    check("rd_arburst", 64'(io_master_arburst), 64'd1);
    check("rd_arid", 64'(io_master_arid), 64'd0);
    check("rd_req_ready_busy", 64'(req_ready), 64'd0);
    wait_resp(start + 1);
    check("rd_latency", 64'(resp_cyc_q[$]), 64'(acc + 3));

    // stalled read: arready low 5 cycles, rvalid 4 cycles late
    slave_idle();
    push_read(1'b0, 64'h1122_3344_5566_7788);
    start = resp_cnt;
    issue(1'b0, 32'h8000_0100, 3'd2, 64'd0, 8'd0, acc);
    for (int i = 0; i < 5; i++) begin
      check("stall_arvalid", 64'(io_master_arvalid), 64'd1);
      check("stall_araddr", 64'(io_master_araddr), 64'h8000_0100);
      check("stall_arsize", 64'(io_master_arsize), 64'd2);
      @(posedge clock); #1;
    end
    io_master_arready = 1'b1;
    @(posedge clock); #1;
    io_master_arready = 1'b0;
    check("stall_ar_drop", 64'(io_master_arvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("stall_rready", 64'(io_master_rready), 64'd1);
      @(posedge clock); #1;
    end
    io_master_rvalid = 1'b1;
    io_master_rdata = 64'h1122_3344_5566_7788;
    wait_resp(start + 1);
    io_master_rvalid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("stall_single_resp", 64'(resp_cnt), 64'(start + 1));

    // write with W lagging AW by 3 cycles, error response
    slave_idle();
    io_master_awready = 1'b1;
    push_write(1'b1);
    start = resp_cnt;
    issue(1'b1, 32'h8000_0010, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, acc);
    check("wr_awvalid", 64'(io_master_awvalid), 64'd1);
    check("wr_wvalid", 64'(io_master_wvalid), 64'd1);
    check("wr_awaddr", 64'(io_master_awaddr), 64'h8000_0010);
    check("wr_awsize", 64'(io_master_awsize), 64'd3);
    check("wr_awlen", 64'(io_master_awlen), 64'd0);
    check("wr_awburst", 64'(io_master_awburst), 64'd1);
    check("wr_awid", 64'(io_master_awid), 64'd0);
    check("wr_wdata", io_master_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    check("wr_wstrb", 64'(io_master_wstrb), 64'h0F);
    check("wr_wlast", 64'(io_master_wlast), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("skew_aw_drop", 64'(io_master_awvalid), 64'd0);
      check("skew_wvalid", 64'(io_master_wvalid), 64'd1);
      check("skew_no_bready", 64'(io_master_bready), 64'd0);
    end
    io_master_wready = 1'b1;
    @(posedge clock); #1;
    io_master_wready = 1'b0;
    check("skew_w_drop", 64'(io_master_wvalid), 64'd0);
    check("skew_bready", 64'(io_master_bready), 64'd1);
    io_master_bvalid = 1'b1;
    io_master_bresp = 2'b10;
    wait_resp(start + 1);
    io_master_bvalid = 1'b0;
    io_master_bresp = 2'b00;

    // read error cases: rlast low, then wrong rid
    slave_ready(64'h0000_0000_AAAA_5555);
    io_master_rlast = 1'b0;
    push_read(1'b1, 64'h0000_0000_AAAA_5555);
    start = resp_cnt;
    issue(1'b0, 32'h8000_0020, 3'd3, 64'd0, 8'd0, acc);
    wait_resp(start + 1);
    io_master_rlast = 1'b1;
    io_master_rid = 4'h3;
    io_master_rdata = 64'h0123_4567_89AB_CDEF;
    push_read(1'b1, 64'h0123_4567_89AB_CDEF);
    issue(1'b0, 32'h8000_0028, 3'd3, 64'd0, 8'd0, acc);
    wait_resp(start + 2);
    io_master_rid = 4'h0;

    // reset while waiting in R
    slave_idle();
    io_master_arready = 1'b1;
    issue(1'b0, 32'h8000_0030, 3'd3, 64'd0, 8'd0, acc);
    @(posedge clock); #1;
    check("rstmid_in_r", 64'(io_master_rready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_rready", 64'(io_master_rready), 64'd0);
    check("rstmid_arvalid", 64'(io_master_arvalid), 64'd0);
    check("rstmid_resp_valid", 64'(resp_valid), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    model_rdata = '0;
    check("rstmid_rdata_cleared", resp_rdata, 64'd0);
    check("rstmid_req_ready", 64'(req_ready), 64'd1);
    slave_ready(64'h0000_0000_0000_BEEF);
    push_read(1'b0, 64'h0000_0000_0000_BEEF);
    start = resp_cnt;
    issue(1'b0, 32'h8000_0040, 3'd3, 64'd0, 8'd0, acc);
    wait_resp(start + 1);
    check("rstmid_latency", 64'(resp_cyc_q[$]), 64'(acc + 3));

    // back-to-back alternating read/write with req_valid held high
    slave_ready(64'd0);
    resp_cyc_q.delete();
    start = resp_cnt;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!req_ready && n < 20) begin
        @(posedge clock); #1; n++;
      end
      req_valid = 1'b1;
      req_we = i[0];
      req_addr = 32'h8000_0200 + 32'(i * 8);
      req_size = 3'd3;
      req_wdata = 64'h5A5A_0000_0000_0000 | 64'(i);
      req_wstrb = 8'hFF;
      if (i[0]) begin
        push_write(1'b0);
      end else begin
        io_master_rdata = 64'hB2B0_0000_0000_0000 | 64'(i);
        push_read(1'b0, io_master_rdata);
      end
      acc_q[i] = cyc;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    wait_resp(start + 4);
    for (int i = 0; i < 4; i++) begin
      check("b2b_accept_cycle", 64'(acc_q[i]), 64'(acc_q[0] + 3 * i));
      if (resp_cyc_q.size() > i)
        check("b2b_resp_cycle", 64'(resp_cyc_q[i]), 64'(acc_q[0] + 3 + 3 * i));
      else
        check("b2b_resp_missing", 64'(resp_cyc_q.size()), 64'(i + 1));
    end

    repeat (3) @(posedge clock);
    #1;
    check("channel_overlap", 64'(overlap_cnt), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_master_bridge.md
# axi4_master_bridge

Single-outstanding AXI4 initiator that turns a simple core-side request/response port into single-beat AXI4 read and write transactions on the `io_master_*` bus. It sits between the core's load/store or fetch unit and the memory subsystem, and drives the slave side of the AXI4 memory model. Only one transaction is in flight at a time.

## Interface
Parameters:
- `ID`, 4'h0: constant value driven on `awid`/`arid`; `rid`/`bid` are checked against it.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  core request present
- `req_ready`  out  1  bridge can accept a request (high only in IDLE)
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  32  byte address, forwarded unmodified
- `req_size`  in  3  AXI size encoding (0 = 1 B … 3 = 8 B)
- `req_wdata`  in  64  write data
- `req_wstrb`  in  8  write byte strobes
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure
- `resp_rdata`  out  64  read data; holds its value until the next read completes
- `resp_err`  out  1  valid with `resp_valid`: error flag (see Operation)
- AW channel: `io_master_awready` in 1; `io_master_awvalid` out 1; `io_master_awaddr` out 32; `io_master_awid` out 4; `io_master_awlen` out 8; `io_master_awsize` out 3; `io_master_awburst` out 2
- W channel: `io_master_wready` in 1; `io_master_wvalid` out 1; `io_master_wdata` out 64; `io_master_wstrb` out 8; `io_master_wlast` out 1
- B channel: `io_master_bready` out 1; `io_master_bvalid` in 1; `io_master_bresp` in 2; `io_master_bid` in 4
- AR channel: `io_master_arready` in 1; `io_master_arvalid` out 1; `io_master_araddr` out 32; `io_master_arid` out 4; `io_master_arlen` out 8; `io_master_arsize` out 3; `io_master_arburst` out 2
- R channel: `io_master_rready` out 1; `io_master_rvalid` in 1; `io_master_rresp` in 2; `io_master_rdata` in 64; `io_master_rlast` in 1; `io_master_rid` in 4

## Operation
- **FSM states:** IDLE, AR, R, WR, B.
- **Request acceptance:**
  - A request is accepted on `req_valid & req_ready`.
  - Address, size, wdata and wstrb are captured into registers at acceptance.
  - `req_we` selects the next state: WR for writes, AR for reads.
- **Fixed AXI fields:** `*len` = 0, `*burst` = 2'b01 (INCR), `*id` = `ID`, `wlast` = 1.
- **AR state:**
  - `arvalid` = 1. Address and size are stable while `arvalid` is high.
  - On `arready`, go to R.
- **R state:**
  - `rready` = 1.
  - On `rvalid`: capture `rdata`, pulse the response, return to IDLE.
- **WR state:**
  - `awvalid` and `wvalid` both start at 1.
  - Each drops independently after its own handshake; two flags record which handshakes are done.
  - When both are done (this can happen in the same cycle), go to B.
- **B state:**
  - `bready` = 1.
  - On `bvalid`: pulse the response, return to IDLE.
- **Error flag:**
  - Read: `resp_err` = `rresp[1] | ~rlast | (rid != ID)`.
  - Write: `resp_err` = `bresp[1] | (bid != ID)`.
- **Ready outside their states:** `rready` and `bready` are 0 outside R and B. A slave that holds `rvalid` or `bvalid` high permanently has no effect until the corresponding state is entered.
- **Reset:**
  - All `*valid`/`*ready` outputs, `resp_valid` and `resp_err` are 0.
  - `resp_rdata` = 0, all address/data/size registers = 0, FSM = IDLE.
  - `req_ready` = 1 once `rst_n` is high.
  - Reset asserted mid-transaction drops every valid immediately (asynchronous) and abandons the transaction; no response is produced.

## Timing
- All AXI outputs and `resp_*` are registered, with no combinational path from inputs to outputs. The one exception is `req_ready`, which decodes from state only.
- **Read latency** (always-ready slave, `rvalid` high):
  - cycle 0: request accepted;
  - cycle 1: `arvalid` = 1, handshake;
  - cycle 2: `rready` = 1, data handshake;
  - cycle 3: `resp_valid` = 1, `req_ready` = 1.
- **Write latency** (`awready`/`wready`/`bvalid` high): accept at cycle 0, AW+W at cycle 1, B at cycle 2, `resp_valid` at cycle 3.
- **Next request:** can be accepted in the same cycle that `resp_valid` is high. Back-to-back throughput is one transaction per 3 cycles.
- **Stall:** with `arready`/`awready`/`wready` low, valids and payloads hold indefinitely.

## Test plan
- **Read, always-ready slave:** `rvalid` = 1, `rdata` = 64'h00000413, `rresp` = 0, `rlast` = 1, `rid` = 0. Read of addr 0x80000000, size 3. Required: `araddr` = 0x80000000, `arsize` = 3, `arlen` = 0; `resp_valid` exactly at cycle 3 with `resp_rdata` = 64'h00000413, `resp_err` = 0.
- **Stalled read:** `arready` low for 5 cycles, then `rvalid` delayed 4 cycles. Required: `arvalid` stays high with a stable address for all 5 cycles; `rready` stays high; a single `resp_valid` pulse appears.
- **Write with AW/W skew:** write addr 0x80000010, wdata 64'hDEADBEEF_CAFEF00D, wstrb 8'h0F. `wready` rises 3 cycles after `awready`. Required: `awvalid` drops after its handshake while `wvalid` stays high; `bready` is asserted only after both handshakes; `bresp` = 2'b10 gives `resp_err` = 1.
- **Read error cases:** `rlast` = 0 returns `resp_err` = 1; `rid` = 4'h3 with `ID` = 0 returns `resp_err` = 1.
- **Reset mid-operation:** drop `rst_n` while in R. Required: `rready`, `arvalid` and `resp_valid` go to 0 immediately; after release, `req_ready` = 1 and a new read completes normally.
- **Back-to-back:** hold `req_valid` high for 4 requests (alternating read/write). Required: 4 `resp_valid` pulses at cycles 3, 6, 9, 12; no handshake overlaps between channels.
